// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one line-wide memory port between the icache and
// the dcache. One transaction is outstanding at a time; it is latched at grant,
// issued with a ready handshake, and its response is routed back to the owner.
module line_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic ICACHE = 1'b0;
    localparam logic DCACHE = 1'b1;

    // Clears the byte-within-line bits so memory always sees a line address.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b0};

    state_t                state;
    logic                  owner;
    logic                  last_grant;
    logic                  op_write;
    logic                  rst_drain;
    logic                  i_pend;
    logic                  d_pend;
    logic                  grant_d;
    logic                  complete;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // Pending/grant decode and detection of the cycle the memory finishes
    always_comb begin
        i_pend   = i_read;
        d_pend   = d_read | d_write;
        // Ties go to whichever side did not win last time.
        grant_d  = d_pend & (~i_pend | (last_grant == ICACHE));
        sel_addr = grant_d ? d_addr : i_addr;
        // A response together with ready at issue is a legal zero-wait completion.
        complete = mem_resp & ((state == WAIT) | ((state == ISSUE) & mem_ready));
    end

    // Transaction FSM with registered memory-side and cache-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= ICACHE;
            last_grant <= ICACHE;
            op_write   <= 1'b0;
            rst_drain  <= 1'b1;
            mem_addr   <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_wdata  <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_pend | d_pend) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        // A simultaneous read+write from the dcache is served as a write.
                        op_write   <= grant_d & d_write;
                        mem_addr   <= sel_addr & LINE_MASK;
                        mem_read   <= ~(grant_d & d_write);
                        mem_write  <= grant_d & d_write;
                        if (grant_d & d_write) begin
                            mem_wdata <= d_wdata;
                        end
                        rst_drain  <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= complete ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Back to IDLE before re-arbitrating so the owner can drop its request.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (complete) begin
                i_resp <= (owner == ICACHE);
                d_resp <= (owner == DCACHE);
                if (!op_write && owner == ICACHE) begin
                    i_rdata <= mem_rdata;
                end
                if (!op_write && owner == DCACHE) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    // Flag illegal dcache request encodings and responses with nothing outstanding;
    // a response straggling in right after reset belongs to a dropped transaction.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(state == IDLE && d_read && d_write))
                else $error("line_mem_arbiter: d_read and d_write asserted together");
            assert (!mem_resp || complete || (state == IDLE && rst_drain))
                else $error("line_mem_arbiter: spurious mem_resp ignored");
        end
    end

endmodule
